fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//  Sequencer/configurator for the 5-tap direct-form FIR datapath (12.10 in, 12.11 coefs, 22.18 out).
//  Holds a shadow and an active coefficient bank and streams samples into the free-running filter.
//  Commits coefficient updates atomically by flushing the delay line with zeros.
//  Tags every filter output valid or invalid. Sits between the sample source and the FIR instance.
// PARAMETERS
//  TAPS     5   number of coefficients (c0..c4)
//  LATENCY  2   filter clocks from filt_in sampled to filt_out registered (input FF + output FF)
//  FLUSH_N  6   zero samples driven per commit; must equal LATENCY+TAPS-1
// PORTS
//  clk          in   1   rising-edge clock
//  rstn         in   1   async active-low reset
//  coef_we      in   1   write shadow coefficient coef_idx
//  coef_idx     in   3   shadow index 0..4; values 5..7 are ignored
//  coef_wdata   in   12  signed Q1.11 coefficient
//  coef_commit  in   1   pulse: request shadow->active copy
//  commit_busy  out  1   commit pending/in progress (FLUSH or COMMIT state)
//  in_valid     in   1   sample offered
//  in_ready     out  1   sample accepted when in_valid&in_ready
//  in_data      in   12  signed 12.10 sample
//  filt_in      out  12  to FIR direct_in (combinational from in_data or 0)
//  filt_c0..c4  out  12  active bank to FIR c0..c4
//  filt_out     in   22  from FIR direct_out
//  out_valid    out  1   out_data is a result of a real accepted sample
//  out_data     out  22  = filt_out (pass-through)
//  underrun     out  1   sticky: RUN cycle with in_valid=0; cleared by coef_commit
// BEHAVIOUR
//  Reset (rstn=0, async): state=EMPTY; both banks=0; valid tag pipe=0; in_ready=0;
//   out_valid=0; commit_busy=0; underrun=0; flush counter=0.
//  Shadow write: any state, 1 cycle; coef_we with idx>4 has no effect.
//  Write+commit in the same cycle: the write is included in the commit.
//  FSM:
//   EMPTY : in_ready=0, filt_in=0; coef_commit -> FLUSH.
//   RUN   : in_ready=1; filt_in=in_valid?in_data:0.
//           Bubble (in_valid=0): 0 is fed, tag=0, underrun<=1.
//           coef_commit -> FLUSH; a sample offered in that same cycle IS accepted.
//   FLUSH : in_ready=0, filt_in=0, tag=0, commit_busy=1; runs FLUSH_N cycles (counter 0..FLUSH_N-1),
//           then -> COMMIT.
//   COMMIT: one cycle; active<=shadow, commit_busy=1, filt_in=0, in_ready=0; next state RUN.
//  coef_commit while in FLUSH/COMMIT is ignored; the shadow snapshot is taken at COMMIT.
//  Valid tagging: LATENCY-deep shift register, input = accepted (in_valid&in_ready).
//   out_valid = last stage. Exactly one out_valid per accepted sample, LATENCY cycles later.
//   In-flight samples at FLUSH entry still emerge valid; they use the OLD bank, which is unchanged until COMMIT.
//  First valid output after COMMIT sees a fully zeroed delay line (no old-sample contamination).
//  filt_c* change only at the COMMIT->RUN edge. No other path modifies the active bank.
//  No downstream backpressure: out_valid is a pulse stream at up to 1/clk.
//  rstn asserted mid-FLUSH: the commit is abandoned, state=EMPTY, and the previous active bank is lost (zeroed).
// TESTING
//  1 reset, then write idx0..4 = 12'h200 (0.25), commit: commit_busy high 7 cycles (6 FLUSH + 1 COMMIT);
//    filt_c*=12'h200 on cycle 8; in_ready rises the same cycle.
//  2 continuous impulse 12'h400 (1.0) then zeros: out_valid every cycle, 2 cycles after acceptance;
//    out_data follows the filter's impulse response.
//  3 in_valid low 3 cycles in RUN: 3 zero samples fed; no out_valid for them; underrun=1 until next commit.
//  4 commit mid-stream with 2 samples in flight: both emerge valid with old-coef result;
//    next valid output comes after 7 stall cycles; c* switch atomically.
//  5 coef_we idx=6, then commit: bank unchanged. Commit during FLUSH: ignored, single COMMIT pulse.
//  6 rstn pulse low during FLUSH cycle 3: all outputs zero asynchronously; EMPTY; in_ready=0 until a new commit.

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// Sample-in, result-out and coefficient-configuration signals of the FIR sequencer.
// The slave modport is the sequencer side; master is the source/sink side.
interface fir_seq_ctrl_if;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned COEF_W = 12;
   localparam int unsigned OUT_W  = 22;
   localparam int unsigned IDX_W  = 3;

   logic               coef_we;
   logic [IDX_W-1:0]   coef_idx;
   logic [COEF_W-1:0]  coef_wdata;
   logic               coef_commit;
   logic               commit_busy;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic               out_valid;
   logic [OUT_W-1:0]   out_data;
   logic               underrun;

   modport slave (
      input  coef_we, coef_idx, coef_wdata, coef_commit, in_valid, in_data,
      output commit_busy, in_ready, out_valid, out_data, underrun
   );

   modport master (
      output coef_we, coef_idx, coef_wdata, coef_commit, in_valid, in_data,
      input  commit_busy, in_ready, out_valid, out_data, underrun
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a 5-tap free-running FIR: shadow/active coefficient banks, zero-flush on
// commit so the first post-commit result never mixes old samples, and a valid tag per result.
module fir_seq_ctrl (
   input  logic                clk,
   input  logic                rstn,
   fir_seq_ctrl_if.slave       bus,
   output logic [11:0]         filt_in,
   output logic [11:0]         filt_c0,
   output logic [11:0]         filt_c1,
   output logic [11:0]         filt_c2,
   output logic [11:0]         filt_c3,
   output logic [11:0]         filt_c4,
   input  logic [21:0]         filt_out
);
   localparam int unsigned TAPS    = 5;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned FLUSH_N = LATENCY + TAPS - 1;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned COEF_W  = 12;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned CNT_W   = 3;

   typedef enum logic [1:0] {S_EMPTY, S_RUN, S_FLUSH, S_COMMIT} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    flush_cnt;
   logic                flush_last;
   logic                accept;
   logic [LATENCY-1:0]  tag_pipe;
   logic [COEF_W-1:0]   shadow [TAPS];
   logic [COEF_W-1:0]   active [TAPS];

   assign flush_last = (flush_cnt == CNT_W'(FLUSH_N - 1));
   assign accept     = bus.in_valid & bus.in_ready;
   assign filt_in    = accept ? bus.in_data : DATA_W'(0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_EMPTY;
      else       state <= state_nxt;
   end

   // Commit requests are only honoured from EMPTY or RUN; FLUSH/COMMIT ignore them.
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY:  if (bus.coef_commit) state_nxt = S_FLUSH;
         S_RUN:    if (bus.coef_commit) state_nxt = S_FLUSH;
         S_FLUSH:  if (flush_last)      state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_RUN;
         default:  state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flush_cnt       <= '0;
         bus.in_ready    <= 1'b0;
         bus.commit_busy <= 1'b0;
      end else begin
         flush_cnt       <= (state == S_FLUSH && !flush_last) ? flush_cnt + CNT_W'(1) : '0;
         bus.in_ready    <= (state_nxt == S_RUN);
         bus.commit_busy <= (state_nxt == S_FLUSH) || (state_nxt == S_COMMIT);
      end
   end

   // Valid tag travels alongside the sample through the filter's register stages.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tag_pipe <= '0;
      else       tag_pipe <= {tag_pipe[LATENCY-2:0], accept};
   end

   assign bus.out_valid = tag_pipe[LATENCY-1];
   assign bus.out_data  = filt_out;

   // A commit request clears the sticky flag, even if a bubble coincides with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                               bus.underrun <= 1'b0;
      else if (bus.coef_commit)                bus.underrun <= 1'b0;
      else if (bus.in_ready && !bus.in_valid)  bus.underrun <= 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < TAPS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (bus.coef_we && (bus.coef_idx < IDX_W'(TAPS))) shadow[bus.coef_idx] <= bus.coef_wdata;
         if (state == S_COMMIT) begin
            for (int i = 0; i < TAPS; i++) active[i] <= shadow[i];
         end
      end
   end

   assign filt_c0 = active[0];
   assign filt_c1 = active[1];
   assign filt_c2 = active[2];
   assign filt_c3 = active[3];
   assign filt_c4 = active[4];
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a behavioural 5-tap FIR and a scoreboard that
// checks every tagged result's value and arrival cycle.
module tb_fir_seq_ctrl;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fir_seq_ctrl_if bus ();

   logic [11:0] filt_in;
   logic [11:0] fc0, fc1, fc2, fc3, fc4;
   logic [21:0] filt_out = '0;

   fir_seq_ctrl u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .filt_in  (filt_in),
      .filt_c0  (fc0),
      .filt_c1  (fc1),
      .filt_c2  (fc2),
      .filt_c3  (fc3),
      .filt_c4  (fc4),
      .filt_out (filt_out)
   );

   // Free-running direct-form FIR: input register feeds the tap line, output is registered.
   logic signed [11:0] dl [5] = '{default: '0};
   logic [11:0] cf [5];
   assign cf[0] = fc0;
   assign cf[1] = fc1;
   assign cf[2] = fc2;
   assign cf[3] = fc3;
   assign cf[4] = fc4;

   function automatic logic [21:0] fir_sum();
      logic signed [26:0] acc;
      acc = '0;
      for (int i = 0; i < 5; i++) acc = acc + 27'($signed(cf[i]) * dl[i]);
      return 22'(acc >>> 3);
   endfunction

   always @(posedge clk) begin
      filt_out <= fir_sum();
      dl[0]    <= $signed(filt_in);
      for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [21:0] data;
      int          cyc;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every tagged result must match the next queued expectation.
   always @(negedge clk) begin
      if (rstn && bus.out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out_data %0h with empty scoreboard (cyc %0d)",
                     bus.out_data, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(mon_e.data));
            chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [11:0] d, input bit has_exp,
                        input logic [21:0] ex, input bit we, input logic [2:0] idx,
                        input logic [11:0] wd, input bit cm);
      exp_t e;
      bus.in_valid    = v;
      bus.in_data     = d;
      bus.coef_we     = we;
      bus.coef_idx    = idx;
      bus.coef_wdata  = wd;
      bus.coef_commit = cm;
      if (has_exp) begin
         e.data = ex;
         e.cyc  = cyc + 2;
         q.push_back(e);
      end
      step();
      bus.in_valid    = 1'b0;
      bus.coef_we     = 1'b0;
      bus.coef_commit = 1'b0;
   endtask

   task automatic send(input logic [11:0] d, input logic [21:0] ex);
      drive(1'b1, d, 1'b1, ex, 1'b0, 3'd0, 12'h000, 1'b0);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [11:0] wd);
      drive(1'b0, 12'h000, 1'b0, 22'h0, 1'b1, idx, wd, 1'b0);
   endtask

   task automatic commit();
      drive(1'b0, 12'h000, 1'b0, 22'h0, 1'b0, 3'd0, 12'h000, 1'b1);
   endtask

   // Counts busy cycles (bounded); optionally re-pulses coef_commit on busy cycle pulse_at.
   task automatic count_busy(input int pulse_at, output int n);
      n = 0;
      while (bus.commit_busy && n < 20) begin
         bus.coef_commit = (n == pulse_at);
         n++;
         step();
      end
      bus.coef_commit = 1'b0;
   endtask

   int n;

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.coef_we = 1'b0;
      bus.coef_idx = '0; bus.coef_wdata = '0; bus.coef_commit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_commit_busy", 64'(bus.commit_busy), 64'd0);
      chk("rst_underrun", 64'(bus.underrun), 64'd0);
      chk("rst_bank", 64'({fc0, fc1, fc2, fc3, fc4}), 64'd0);
      chk("rst_filt_in", 64'(filt_in), 64'd0);
      rstn = 1'b1;
      step();

      // 1: load 0.25 everywhere, last write shares the commit cycle
      for (int i = 0; i < 4; i++) wr(3'(i), 12'h200);
      drive(1'b0, 12'h000, 1'b0, 22'h0, 1'b1, 3'd4, 12'h200, 1'b1);
      chk("t1_bank_held", 64'({fc0, fc1, fc2, fc3, fc4}), 64'd0);
      count_busy(-1, n);
      chk("t1_busy_cycles", 64'(n), 64'd7);
      chk("t1_bank", 64'({fc0, fc1, fc2, fc3, fc4}),
          64'({12'h200, 12'h200, 12'h200, 12'h200, 12'h200}));
      chk("t1_in_ready", 64'(bus.in_ready), 64'd1);

      // 2: impulse response of 0.25-flat filter
      send(12'h400, 22'h10000);
      for (int i = 0; i < 4; i++) send(12'h000, 22'h10000);
      send(12'h000, 22'h00000);
      chk("t2_underrun", 64'(bus.underrun), 64'd0);

      // 3: three bubbles (shadow writes ride along), then two samples
      wr(3'd0, 12'h400);
      wr(3'd1, 12'h000);
      wr(3'd2, 12'h000);
      chk("t3_underrun_set", 64'(bus.underrun), 64'd1);
      drive(1'b1, 12'h400, 1'b1, 22'h10000, 1'b1, 3'd3, 12'h000, 1'b0);
      drive(1'b1, 12'h200, 1'b1, 22'h18000, 1'b1, 3'd4, 12'h400, 1'b0);
      chk("t3_underrun_sticky", 64'(bus.underrun), 64'd1);
      chk("t3_bank_unchanged", 64'({fc0, fc1, fc2, fc3, fc4}),
          64'({12'h200, 12'h200, 12'h200, 12'h200, 12'h200}));

      // 4: commit with two samples in flight; blocked offers during the stall
      send(12'h100, 22'h1C000);
      drive(1'b1, 12'h100, 1'b1, 22'h20000, 1'b0, 3'd0, 12'h000, 1'b1);
      chk("t4_underrun_clr", 64'(bus.underrun), 64'd0);
      chk("t4_bank_old", 64'({fc0, fc1, fc2, fc3, fc4}),
          64'({12'h200, 12'h200, 12'h200, 12'h200, 12'h200}));
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h7FF;
      count_busy(-1, n);
      chk("t4_busy_cycles", 64'(n), 64'd7);
      chk("t4_bank_new", 64'({fc0, fc1, fc2, fc3, fc4}),
          64'({12'h400, 12'h000, 12'h000, 12'h000, 12'h400}));
      for (int i = 0; i < 4; i++) send(12'h400, 22'h20000);
      send(12'h400, 22'h40000);

      // 5: out-of-range index write, then a commit re-requested mid-flush
      wr(3'd6, 12'h7FF);
      commit();
      count_busy(2, n);
      chk("t5_busy_cycles", 64'(n), 64'd7);
      chk("t5_bank", 64'({fc0, fc1, fc2, fc3, fc4}),
          64'({12'h400, 12'h000, 12'h000, 12'h000, 12'h400}));
      chk("t5_in_ready", 64'(bus.in_ready), 64'd1);

      // 6: reset asserted during the third flush cycle
      wr(3'd1, 12'h123);
      commit();
      step();
      step();
      #2 rstn = 1'b0;
      #1;
      chk("t6_commit_busy", 64'(bus.commit_busy), 64'd0);
      chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_underrun", 64'(bus.underrun), 64'd0);
      chk("t6_bank", 64'({fc0, fc1, fc2, fc3, fc4}), 64'd0);
      rstn = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h3AA;
      repeat (3) step();
      chk("t6_empty_ready", 64'(bus.in_ready), 64'd0);
      chk("t6_empty_busy", 64'(bus.commit_busy), 64'd0);
      bus.in_valid = 1'b0;
      commit();
      count_busy(-1, n);
      chk("t6_busy_cycles", 64'(n), 64'd7);
      chk("t6_bank_shadow_lost", 64'({fc0, fc1, fc2, fc3, fc4}), 64'd0);
      chk("t6_in_ready_run", 64'(bus.in_ready), 64'd1);

      repeat (4) step();
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
